// File: rtl/mprc_probe_unit_pkg.sv
// Purpose: shared widths, coherence/probe codes, FSM encoding and the latched
//          probe payload for the D-cache probe handler.
// Ports:   none (package).
package mprc_probe_unit_pkg;

    localparam int unsigned ADDR_W      = 40;
    localparam int unsigned BLK_OFF     = 6;
    localparam int unsigned IDX_BITS    = 6;
    localparam int unsigned NWAYS       = 4;
    localparam int unsigned BLK_ADDR_W  = ADDR_W - BLK_OFF;
    localparam int unsigned TAG_W       = ADDR_W - BLK_OFF - IDX_BITS;
    localparam int unsigned COH_W       = 2;
    localparam int unsigned PARAM_W     = 2;
    localparam int unsigned REL_PARAM_W = 2 * COH_W;

    // Coherence states held in the meta array
    localparam logic [COH_W-1:0] COH_N = 2'd0;
    localparam logic [COH_W-1:0] COH_B = 2'd1;
    localparam logic [COH_W-1:0] COH_T = 2'd2;
    localparam logic [COH_W-1:0] COH_D = 2'd3;

    // Probe permission targets; code 3 behaves like toN
    localparam logic [PARAM_W-1:0] PRM_TOT = 2'd0;
    localparam logic [PARAM_W-1:0] PRM_TOB = 2'd1;
    localparam logic [PARAM_W-1:0] PRM_TON = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_META_READ  = 4'd1,
        ST_META_RESP  = 4'd2,
        ST_MSHR_REQ   = 4'd3,
        ST_RELEASE    = 4'd4,
        ST_WB_REQ     = 4'd5,
        ST_WB_RESP    = 4'd6,
        ST_META_WRITE = 4'd7
    } fsm_state_e;

    typedef struct packed {
        logic [BLK_ADDR_W-1:0] addr;
        logic [PARAM_W-1:0]    param;
    } probe_req_t;

endpackage

// File: rtl/mprc_probe_unit_if.sv
// Purpose: bundles the probe, meta array, release and writeback handshakes.
// Modports: master = probe unit side, slave = cache / outer-level side.
interface mprc_probe_unit_if
    import mprc_probe_unit_pkg::*;
();
    logic                    probe_valid;
    logic                    probe_ready;
    logic [BLK_ADDR_W-1:0]   probe_addr;
    logic [PARAM_W-1:0]      probe_param;

    logic                    meta_rd_valid;
    logic                    meta_rd_ready;
    logic [IDX_BITS-1:0]     meta_rd_idx;
    logic [NWAYS-1:0]        tag_way_en;
    logic [COH_W-1:0]        tag_state;

    logic                    mshr_rdy;
    logic                    lrsc_valid;

    logic                    rel_valid;
    logic                    rel_ready;
    logic [BLK_ADDR_W-1:0]   rel_addr;
    logic [REL_PARAM_W-1:0]  rel_param;

    logic                    wb_req_valid;
    logic                    wb_req_ready;
    logic [NWAYS-1:0]        wb_way_en;
    logic                    wb_done;

    logic                    meta_wr_valid;
    logic                    meta_wr_ready;
    logic [IDX_BITS-1:0]     meta_wr_idx;
    logic [NWAYS-1:0]        meta_wr_way_en;
    logic [TAG_W-1:0]        meta_wr_tag;
    logic [COH_W-1:0]        meta_wr_state;

    logic                    busy;

    modport master (
        input  probe_valid, probe_addr, probe_param,
        output probe_ready,
        output meta_rd_valid, meta_rd_idx,
        input  meta_rd_ready, tag_way_en, tag_state,
        input  mshr_rdy, lrsc_valid,
        output rel_valid, rel_addr, rel_param,
        input  rel_ready,
        output wb_req_valid, wb_way_en,
        input  wb_req_ready, wb_done,
        output meta_wr_valid, meta_wr_idx, meta_wr_way_en, meta_wr_tag, meta_wr_state,
        input  meta_wr_ready,
        output busy
    );

    modport slave (
        output probe_valid, probe_addr, probe_param,
        input  probe_ready,
        input  meta_rd_valid, meta_rd_idx,
        output meta_rd_ready, tag_way_en, tag_state,
        output mshr_rdy, lrsc_valid,
        input  rel_valid, rel_addr, rel_param,
        output rel_ready,
        input  wb_req_valid, wb_way_en,
        output wb_req_ready, wb_done,
        input  meta_wr_valid, meta_wr_idx, meta_wr_way_en, meta_wr_tag, meta_wr_state,
        output meta_wr_ready,
        input  busy
    );

endinterface

// File: rtl/mprc_probe_shrink.sv
// Purpose: maps the current line state and probe target to the reduced state
//          and the {old,new} release parameter.
// Ports:   old_state   in  current state (N when the probe missed)
//          probe_param in  probe target code
//          new_state_c out reduced state
//          rel_param_c out {old_state, new_state_c}
module mprc_probe_shrink
    import mprc_probe_unit_pkg::*;
(
    input  logic [COH_W-1:0]       old_state,
    input  logic [PARAM_W-1:0]     probe_param,
    output logic [COH_W-1:0]       new_state_c,
    output logic [REL_PARAM_W-1:0] rel_param_c
);

    // toT keeps the state, toB caps at Branch, toN (and code 3) invalidates
    always_comb begin
        new_state_c = COH_N;
        unique case (probe_param)
            PRM_TOT: new_state_c = old_state;
            PRM_TOB: new_state_c = (old_state > COH_B) ? COH_B : old_state;
            PRM_TON: new_state_c = COH_N;
            default: new_state_c = COH_N;
        endcase
        rel_param_c = {old_state, new_state_c};
    end

endmodule

// File: rtl/mprc_probe_unit.sv
// Purpose: coherence probe handler. Reads tag/meta for one probe at a time,
//          retries while an LR reservation or an MSHR holds the block, then
//          releases (or writes back if dirty) and rewrites the line state.
// Ports:   clk     in  clock
//          reset_n in  synchronous reset, active low
//          bus     master side of mprc_probe_unit_if (probe, meta rd/wr,
//                  release, writeback, lrsc/mshr status, busy)
module mprc_probe_unit
    import mprc_probe_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    mprc_probe_unit_if.master bus
);

    fsm_state_e              state_q, state_d;
    probe_req_t              req_q, req_d;
    logic [NWAYS-1:0]        way_q, way_d;
    logic [COH_W-1:0]        new_state_q, new_state_d;
    logic [REL_PARAM_W-1:0]  rel_param_q, rel_param_d;
    logic                    hit_q, hit_d;

    logic probe_ready_q, probe_ready_d;
    logic busy_q, busy_d;
    logic meta_rd_valid_q, meta_rd_valid_d;
    logic rel_valid_q, rel_valid_d;
    logic wb_req_valid_q, wb_req_valid_d;
    logic meta_wr_valid_q, meta_wr_valid_d;

    logic                   hit_c;
    logic [COH_W-1:0]       shrink_old_c;
    logic [COH_W-1:0]       shrink_new_c;
    logic [REL_PARAM_W-1:0] shrink_rel_c;

    // A way match on an invalid line counts as a miss
    assign hit_c        = (|bus.tag_way_en) && (bus.tag_state != COH_N);
    assign shrink_old_c = hit_c ? bus.tag_state : COH_N;

    mprc_probe_shrink u_shrink (
        .old_state   (shrink_old_c),
        .probe_param (req_q.param),
        .new_state_c (shrink_new_c),
        .rel_param_c (shrink_rel_c)
    );

    // Next-state and latch updates
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        way_d       = way_q;
        new_state_d = new_state_q;
        rel_param_d = rel_param_q;
        hit_d       = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.probe_valid) begin
                    req_d.addr  = bus.probe_addr;
                    req_d.param = bus.probe_param;
                    state_d     = ST_META_READ;
                end
            end
            ST_META_READ: begin
                if (bus.meta_rd_ready) state_d = ST_META_RESP;
            end
            ST_META_RESP: state_d = ST_MSHR_REQ;
            ST_MSHR_REQ: begin
                // A live reservation or an owning MSHR forces a fresh tag read
                if (bus.lrsc_valid || !bus.mshr_rdy) begin
                    state_d = ST_META_READ;
                end else begin
                    way_d       = bus.tag_way_en;
                    hit_d       = hit_c;
                    new_state_d = shrink_new_c;
                    rel_param_d = shrink_rel_c;
                    state_d     = (hit_c && (bus.tag_state == COH_D)) ? ST_WB_REQ : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (bus.rel_ready) state_d = hit_q ? ST_META_WRITE : ST_IDLE;
            end
            ST_WB_REQ: begin
                if (bus.wb_req_ready) state_d = ST_WB_RESP;
            end
            ST_WB_RESP: begin
                if (bus.wb_done) state_d = ST_META_WRITE;
            end
            ST_META_WRITE: begin
                if (bus.meta_wr_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the next state
    always_comb begin
        probe_ready_d   = (state_d == ST_IDLE);
        busy_d          = (state_d != ST_IDLE);
        meta_rd_valid_d = (state_d == ST_META_READ);
        rel_valid_d     = (state_d == ST_RELEASE);
        wb_req_valid_d  = (state_d == ST_WB_REQ);
        meta_wr_valid_d = (state_d == ST_META_WRITE);
    end

    // Control flops
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            probe_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            meta_rd_valid_q <= 1'b0;
            rel_valid_q     <= 1'b0;
            wb_req_valid_q  <= 1'b0;
            meta_wr_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            probe_ready_q   <= probe_ready_d;
            busy_q          <= busy_d;
            meta_rd_valid_q <= meta_rd_valid_d;
            rel_valid_q     <= rel_valid_d;
            wb_req_valid_q  <= wb_req_valid_d;
            meta_wr_valid_q <= meta_wr_valid_d;
        end
    end

    // Payload latches; contents are irrelevant while idle
    always_ff @(posedge clk) begin
        req_q       <= req_d;
        way_q       <= way_d;
        new_state_q <= new_state_d;
        rel_param_q <= rel_param_d;
        hit_q       <= hit_d;
    end

    assign bus.probe_ready    = probe_ready_q;
    assign bus.busy           = busy_q;
    assign bus.meta_rd_valid  = meta_rd_valid_q;
    assign bus.meta_rd_idx    = req_q.addr[IDX_BITS-1:0];
    assign bus.rel_valid      = rel_valid_q;
    assign bus.rel_addr       = req_q.addr;
    assign bus.rel_param      = rel_param_q;
    assign bus.wb_req_valid   = wb_req_valid_q;
    assign bus.wb_way_en      = way_q;
    assign bus.meta_wr_valid  = meta_wr_valid_q;
    assign bus.meta_wr_idx    = req_q.addr[IDX_BITS-1:0];
    assign bus.meta_wr_way_en = way_q;
    assign bus.meta_wr_tag    = req_q.addr[BLK_ADDR_W-1:IDX_BITS];
    assign bus.meta_wr_state  = new_state_q;

endmodule
